// File: rtl/imem_load_ctrl.sv
// JTAG-side instruction-memory loader.
// Decodes commands from the I-Mem scan chain, halts the core, and performs
// single-word writes/reads on the I-Mem once the core acknowledges the halt.
// Update protocol: a command is accepted only when upd_i=1 while the FSM is
// idle (busy=0); upd_i while busy is dropped and flagged in err. There is no
// back-pressure beyond busy, which the host polls through scan_o[0].
module imem_load_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int SW = AW + DW + 3
) (
  input  logic          tck_i,
  input  logic          tap_rst_s,
  input  logic          upd_i,
  input  logic [SW-1:0] scan_i,
  output logic [SW-1:0] scan_o,
  input  logic          hold_ack_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [AW-1:0] imem_addr_o,
  output logic [DW-1:0] imem_data_o,
  output logic          imem_we_o,
  output logic          mux_sel_o,
  output logic          cpu_hold_o,
  output logic [2:0]    dbg_state,
  output logic [15:0]   wr_count
);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_WRPT = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    WRITE   = 3'd2,
    RD_WAIT = 3'd3,
    RD_CAP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cmd_q;
  logic [AW-1:0] pointer;
  logic [DW-1:0] rdata_q;
  logic          err;
  logic          err_set;
  logic          ack_meta;
  logic          ack_s;
  logic          busy;
  logic          accept;
  logic          go;

  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_data;
  logic          scan_hold;
  logic [1:0]    scan_cmd;

  assign scan_addr = scan_i[SW-1:DW+3];
  assign scan_data = scan_i[DW+2:3];
  assign scan_hold = scan_i[2];
  assign scan_cmd  = scan_i[1:0];

  assign busy   = (state_q != IDLE);
  assign accept = upd_i && !busy;
  // An access may proceed only while the core is held, acknowledged and the
  // address mux already points at the JTAG side.
  assign go     = mux_sel_o && ack_s && cpu_hold_o;

  // Write strobe comes straight from the state register, so an async reset
  // drops it immediately; it is also gated so it can never assert while the
  // mux is on the CPU side or after the acknowledge has fallen.
  assign imem_we_o = (state_q == WRITE) && mux_sel_o && ack_s;

  assign scan_o    = {pointer, rdata_q, err, ack_s, busy};
  assign dbg_state = state_q;

  // Next-state decode and error detection.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (upd_i) state_d = EXEC;
      end
      EXEC: begin
        if (cmd_q == CMD_NOP) begin
          state_d = IDLE;
        end else if (!go) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else if (cmd_q == CMD_RD) begin
          state_d = RD_WAIT;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (!ack_s || !mux_sel_o) err_set = 1'b1;
      end
      RD_WAIT: begin
        if (!ack_s) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else begin
          state_d = RD_CAP;
        end
      end
      RD_CAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (upd_i && busy) err_set = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge tck_i or posedge tap_rst_s) begin
    if (tap_rst_s) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Command latch, hold request and memory address/data, loaded on accept.
  always_ff @(posedge tck_i or posedge tap_rst_s) begin
    if (tap_rst_s) begin
      cmd_q       <= CMD_NOP;
      cpu_hold_o  <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
    end else if (accept) begin
      cmd_q      <= scan_cmd;
      cpu_hold_o <= scan_hold;
      if (scan_cmd == CMD_WRPT) imem_addr_o <= pointer;
      else if (scan_cmd != CMD_NOP) imem_addr_o <= scan_addr;
      if (scan_cmd == CMD_WR || scan_cmd == CMD_WRPT) imem_data_o <= scan_data;
    end
  end

  // Pointer, write counter and read capture follow completed accesses.
  always_ff @(posedge tck_i or posedge tap_rst_s) begin
    if (tap_rst_s) begin
      pointer  <= '0;
      wr_count <= '0;
      rdata_q  <= '0;
    end else begin
      if (imem_we_o) begin
        pointer  <= imem_addr_o + 1'b1;
        wr_count <= wr_count + 16'd1;
      end
      if (state_q == RD_CAP) rdata_q <= imem_rdata_i;
    end
  end

  // Sticky error: cleared by a hold=1/NOP update, set by any rejected access.
  always_ff @(posedge tck_i or posedge tap_rst_s) begin
    if (tap_rst_s) err <= 1'b0;
    else if (accept && scan_hold && scan_cmd == CMD_NOP) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Halt-acknowledge synchronizer and registered address-mux select.
  always_ff @(posedge tck_i or posedge tap_rst_s) begin
    if (tap_rst_s) begin
      ack_meta  <= 1'b0;
      ack_s     <= 1'b0;
      mux_sel_o <= 1'b0;
    end else begin
      ack_meta  <= hold_ack_i;
      ack_s     <= ack_meta;
      mux_sel_o <= cpu_hold_o && ack_s;
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl: reset, table-driven command vectors,
// hand-written corner sequences and a randomized run against a
// transaction-level model of the loader.
module tb_imem_load_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = AW + DW + 3;

  logic          tck;
  logic          tap_rst_s;
  logic          upd_i;
  logic [SW-1:0] scan_i;
  logic [SW-1:0] scan_o;
  logic          hold_ack_i;
  logic [DW-1:0] imem_rdata_i;
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_data_o;
  logic          imem_we_o;
  logic          mux_sel_o;
  logic          cpu_hold_o;
  logic [2:0]    dbg_state;
  logic [15:0]   wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic [DW-1:0]    ref_mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q[$];

  imem_load_ctrl #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .tck_i        (tck),
    .tap_rst_s    (tap_rst_s),
    .upd_i        (upd_i),
    .scan_i       (scan_i),
    .scan_o       (scan_o),
    .hold_ack_i   (hold_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .imem_we_o    (imem_we_o),
    .mux_sel_o    (mux_sel_o),
    .cpu_hold_o   (cpu_hold_o),
    .dbg_state    (dbg_state),
    .wr_count     (wr_count)
  );

  // Clock / reset
  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Environment memory: combinational read, written on the strobe.
  assign imem_rdata_i = mem[imem_addr_o];
  always @(posedge tck) begin
    if (imem_we_o) mem[imem_addr_o] <= imem_data_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard against the expected-write queue.
  always @(negedge tck) begin
    if (!tap_rst_s && imem_we_o) begin
      check("we_with_mux", mux_sel_o, 1'b1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {imem_addr_o, imem_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("write_addr_data", {imem_addr_o, imem_data_o}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic hold);
    scan_i = {addr, data, hold, cmd};
    upd_i  = 1'b1;
    @(posedge tck);
    #1;
    upd_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (scan_o[0] && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", scan_o[0], 1'b0);
  endtask

  task automatic wait_mux();
    int n = 0;
    while (!mux_sel_o && n < 10) begin
      tick();
      n++;
    end
    check("mux_sel_up", mux_sel_o, 1'b1);
  endtask

  function automatic logic [SW-1:0] exp_scan(input logic [AW-1:0] ptr,
                                             input logic [DW-1:0] rd, input logic e);
    return {ptr, rd, e, 1'b1, 1'b0};
  endfunction

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_wr;
    logic [AW-1:0] exp_waddr;
    logic [AW-1:0] exp_ptr;
    logic [DW-1:0] exp_rdata;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [AW-1:0] m_ptr;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    logic [15:0]   m_cnt;
    logic [AW-1:0] last_addr;
    int            n;

    vecs[0]  = '{2'b01, 10'h005, 32'h0050_0093, 1'b1, 10'h005, 10'h006, 32'h0000_0000, 16'd1};
    vecs[1]  = '{2'b11, 10'h005, 32'h0,         1'b0, 10'h000, 10'h006, 32'h0050_0093, 16'd1};
    vecs[2]  = '{2'b10, 10'h000, 32'h1111_1111, 1'b1, 10'h006, 10'h007, 32'h0050_0093, 16'd2};
    vecs[3]  = '{2'b01, 10'h3FE, 32'h2222_2222, 1'b1, 10'h3FE, 10'h3FF, 32'h0050_0093, 16'd3};
    vecs[4]  = '{2'b10, 10'h000, 32'h3333_3333, 1'b1, 10'h3FF, 10'h000, 32'h0050_0093, 16'd4};
    vecs[5]  = '{2'b10, 10'h000, 32'h4444_4444, 1'b1, 10'h000, 10'h001, 32'h0050_0093, 16'd5};
    vecs[6]  = '{2'b11, 10'h3FF, 32'h0,         1'b0, 10'h000, 10'h001, 32'h3333_3333, 16'd5};
    vecs[7]  = '{2'b11, 10'h000, 32'h0,         1'b0, 10'h000, 10'h001, 32'h4444_4444, 16'd5};
    vecs[8]  = '{2'b11, 10'h010, 32'h0,         1'b0, 10'h000, 10'h001, 32'hDEAD_BEEF, 16'd5};
    vecs[9]  = '{2'b00, 10'h000, 32'h0,         1'b0, 10'h000, 10'h001, 32'hDEAD_BEEF, 16'd5};
    vecs[10] = '{2'b11, 10'h006, 32'h0,         1'b0, 10'h000, 10'h001, 32'h1111_1111, 16'd5};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[10'h010] = 32'hDEAD_BEEF;

    // Reset state
    tap_rst_s  = 1'b1;
    upd_i      = 1'b0;
    scan_i     = '0;
    hold_ack_i = 1'b0;
    repeat (3) tick();
    check("rst_scan_o",   scan_o,      '0);
    check("rst_we",       imem_we_o,   1'b0);
    check("rst_mux",      mux_sel_o,   1'b0);
    check("rst_hold",     cpu_hold_o,  1'b0);
    check("rst_addr",     imem_addr_o, '0);
    check("rst_data",     imem_data_o, '0);
    check("rst_cnt",      wr_count,    16'd0);
    check("rst_state",    dbg_state,   3'd0);
    tap_rst_s = 1'b0;
    tick();

    // No halt acknowledge: write rejected, err set, then cleared
    send(2'b01, 10'h005, 32'h0050_0093, 1'b1);
    wait_idle();
    check("nohalt_err",  scan_o[2], 1'b1);
    check("nohalt_cnt",  wr_count,  16'd0);
    check("nohalt_hold", cpu_hold_o, 1'b1);
    send(2'b00, 10'h000, 32'h0, 1'b1);
    wait_idle();
    check("err_clear", scan_o[2], 1'b0);

    // Halt acknowledged by the core
    hold_ack_i = 1'b1;
    wait_mux();

    // Table-driven command vectors
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].exp_wr) exp_q.push_back({vecs[i].exp_waddr, vecs[i].data});
      send(vecs[i].cmd, vecs[i].addr, vecs[i].data, 1'b1);
      wait_idle();
      check($sformatf("vec%0d_scan", i), scan_o,
            exp_scan(vecs[i].exp_ptr, vecs[i].exp_rdata, 1'b0));
      check($sformatf("vec%0d_cnt", i), wr_count, vecs[i].exp_cnt);
    end

    // Update while busy is ignored and flags err
    send(2'b11, 10'h010, 32'h0, 1'b1);
    scan_i = {10'h020, 32'hBAD0_BAD0, 1'b1, 2'b01};
    upd_i  = 1'b1;
    tick();
    upd_i  = 1'b0;
    wait_idle();
    check("busy_upd_scan", scan_o, exp_scan(10'h001, 32'hDEAD_BEEF, 1'b1));
    check("busy_upd_cnt",  wr_count, 16'd5);
    send(2'b00, 10'h000, 32'h0, 1'b1);
    wait_idle();
    check("busy_err_clear", scan_o[2], 1'b0);

    // Acknowledge drops together with a write command
    scan_i     = {10'h030, 32'hCAFE_0030, 1'b1, 2'b01};
    upd_i      = 1'b1;
    hold_ack_i = 1'b0;
    tick();
    upd_i = 1'b0;
    n = 0;
    while (mux_sel_o && n < 3) begin
      tick();
      n++;
    end
    check("ackdrop_mux", mux_sel_o, 1'b0);
    wait_idle();
    check("ackdrop_err", scan_o[2], 1'b1);
    check("ackdrop_cnt", wr_count, 16'd5);
    hold_ack_i = 1'b1;
    wait_mux();
    send(2'b00, 10'h000, 32'h0, 1'b1);
    wait_idle();
    check("ackdrop_clear", scan_o, exp_scan(10'h001, 32'hDEAD_BEEF, 1'b0));

    // Async reset in the middle of a write cycle
    send(2'b01, 10'h040, 32'h0000_0055, 1'b1);
    tick();
    check("wr_active", imem_we_o, 1'b1);
    #1 tap_rst_s = 1'b1;
    #1;
    check("arst_we",    imem_we_o,   1'b0);
    check("arst_mux",   mux_sel_o,   1'b0);
    check("arst_hold",  cpu_hold_o,  1'b0);
    check("arst_addr",  imem_addr_o, '0);
    check("arst_data",  imem_data_o, '0);
    check("arst_scan",  scan_o,      '0);
    check("arst_cnt",   wr_count,    16'd0);
    tick();
    tap_rst_s = 1'b0;
    tick();
    send(2'b00, 10'h000, 32'h0, 1'b1);
    wait_mux();
    exp_q.push_back({10'h050, 32'h00A0_0113});
    send(2'b01, 10'h050, 32'h00A0_0113, 1'b1);
    wait_idle();
    check("post_rst_cnt",  wr_count, 16'd1);
    check("post_rst_scan", scan_o, exp_scan(10'h051, 32'h0, 1'b0));

    // Randomized commands against the transaction-level model
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
    m_ptr     = 10'h051;
    m_rdata   = '0;
    m_err     = 1'b0;
    m_cnt     = 16'd1;
    last_addr = 10'h050;
    for (int t = 0; t < 40; t++) begin
      logic [1:0]    cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      cmd  = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 1) == 0) ? last_addr : AW'($urandom_range(0, (1 << AW) - 1));
      data = $urandom;
      case (cmd)
        2'b00: m_err = 1'b0;
        2'b01: begin
          ref_mem[addr] = data;
          exp_q.push_back({addr, data});
          last_addr = addr;
          m_ptr = addr + 1'b1;
          m_cnt = m_cnt + 16'd1;
        end
        2'b10: begin
          ref_mem[m_ptr] = data;
          exp_q.push_back({m_ptr, data});
          last_addr = m_ptr;
          m_ptr = m_ptr + 1'b1;
          m_cnt = m_cnt + 16'd1;
        end
        default: m_rdata = ref_mem[addr];
      endcase
      send(cmd, addr, data, 1'b1);
      wait_idle();
      check($sformatf("rnd%0d_scan", t), scan_o, exp_scan(m_ptr, m_rdata, m_err));
      check($sformatf("rnd%0d_cnt", t), wr_count, m_cnt);
    end

    repeat (2) tick();
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter AW, default 10, I-Mem word address width.
REQ-002 Parameter DW, default 32, instruction width.
REQ-003 Parameter SW, default AW+DW+3, scan word width. Layout: [SW-1:DW+3] addr, [DW+2:3] data, [2] hold, [1:0] cmd.
REQ-004 tck_i  in  1  JTAG TCK; the only clock.
REQ-005 tap_rst_s  in  1  reset tap_rst_s, asynchronous, active-high.
REQ-006 upd_i  in  1  Update-DR pulse of the I-Mem scan chain, one TCK cycle wide.
REQ-007 scan_i  in  SW  parallel output of the I-Mem scan chain.
REQ-008 scan_o  out  SW  capture word, loaded into the chain in Capture-DR.
REQ-009 hold_ack_i  in  1  CPU-halted acknowledge from the core clock domain; asynchronous to tck_i.
REQ-010 imem_rdata_i  in  DW  I-Mem read data; combinational from imem_addr_o.
REQ-011 imem_addr_o  out  AW  I-Mem address when the JTAG side owns the memory.
REQ-012 imem_data_o  out  DW  I-Mem write data.
REQ-013 imem_we_o  out  1  I-Mem write strobe.
REQ-014 mux_sel_o  out  1  address mux select: 1 = JTAG address, 0 = CPU PC.
REQ-015 cpu_hold_o  out  1  halt request to the core.

Function
REQ-016 Commands: cmd 00 NOP, 01 WRITE at addr, 10 WRITE at pointer then pointer+1, 11 READ at addr.
REQ-017 On the cycle after upd_i=1, the controller SHALL register scan_i and enter EXEC.
REQ-018 On the same cycle, cpu_hold_o SHALL take the latched hold bit, for every command including NOP.
REQ-019 hold_ack_i SHALL pass through a 2-FF synchronizer (ack_s).
REQ-020 mux_sel_o SHALL equal cpu_hold_o & ack_s, registered.
REQ-021 FSM states SHALL be IDLE, EXEC, WRITE, RD_WAIT, RD_CAP.
REQ-022 IDLE -> EXEC on upd_i.
REQ-023 EXEC with NOP -> IDLE.
REQ-024 EXEC with a WRITE command and mux_sel_o=1 -> WRITE.
REQ-025 EXEC with READ and mux_sel_o=1 -> RD_WAIT -> RD_CAP -> IDLE.
REQ-026 EXEC with any non-NOP command and mux_sel_o=0 -> IDLE; the sticky err flag SHALL be set and no memory access SHALL occur.
REQ-027 WRITE state SHALL last exactly one cycle, with imem_we_o=1 and imem_addr_o/imem_data_o stable from EXEC through WRITE; WRITE -> IDLE.
REQ-028 cmd 01: address = scan addr field. The pointer SHALL be loaded with addr+1 modulo 2^AW.
REQ-029 cmd 10: address = pointer. The pointer SHALL increment modulo 2^AW; 2^AW-1 wraps to 0.
REQ-030 cmd 11: address = scan addr field, held through RD_CAP. In RD_CAP, rdata_q SHALL capture imem_rdata_i.
REQ-031 A 16-bit write counter SHALL increment on each imem_we_o pulse and wrap at 0xFFFF -> 0.
REQ-032 scan_o SHALL be {pointer, rdata_q, err, ack_s, busy}, where busy = (state != IDLE).
REQ-033 A write to the err flag SHALL clear it: any command with hold=1 and cmd=00 while err=1 clears err.
REQ-034 upd_i arriving while busy SHALL be ignored and SHALL set err.
REQ-035 imem_we_o SHALL never be 1 while mux_sel_o=0.
REQ-036 If ack_s falls during EXEC, WRITE or RD_WAIT, the access SHALL be aborted: imem_we_o=0, err set, state -> IDLE.

Reset
REQ-037 On tap_rst_s=1, asynchronously: state=IDLE, imem_we_o=0, mux_sel_o=0, cpu_hold_o=0, imem_addr_o=0, imem_data_o=0, pointer=0, rdata_q=0, counter=0, err=0, synchronizer flops=0.
REQ-038 Reset mid-write SHALL drop imem_we_o in the same instant, without waiting for a clock edge.

Verification
REQ-039 Halt and write: upd with hold=1, NOP; wait until ack_s=1; then upd cmd01 addr=0x005 data=0x00500093. Required: one imem_we_o pulse at 0x005 with that data; pointer=0x006; counter=1.
REQ-040 Auto-increment wrap: pointer=0x3FF (AW=10), then two cmd10 writes. Required: writes at 0x3FF then 0x000; pointer=0x001.
REQ-041 No halt: cmd01 with hold_ack_i=0. Required: no imem_we_o pulse; err=1 in scan_o[2]; a hold=1/cmd00 update then clears err.
REQ-042 Readback: memory word 0x010 = 0xDEADBEEF, cmd11 addr=0x010. Required: rdata_q=0xDEADBEEF two cycles after EXEC; the next capture shows it in scan_o[DW+2:3].
REQ-043 Async reset during WRITE. Required: imem_we_o=0 immediately; all outputs at reset values; next write counter value=1.
REQ-044 Ack drop: hold_ack_i falls during EXEC of a cmd01. Required: no write; err=1; mux_sel_o=0 within 3 TCK cycles.
